// File: rtl/sid_pkg.sv
// sid_pkg
// Shared definitions for the tt_um_sid register-bus slice.
// Contents:
//   REG_*               SID register addresses carried on ui_in[2:0]
//   GATE/TRI/SAW/PULSE  waveform-control bit masks for the REG_WAV register
//   NUM_VOICES_DEFAULT  number of voices implemented by the SID core
//   sid_seq_state_e     write-sequencer state encoding
package sid_pkg;

  localparam logic [2:0] REG_FREQ_LO = 3'd0;
  localparam logic [2:0] REG_FREQ_HI = 3'd1;
  localparam logic [2:0] REG_PW      = 3'd2;
  localparam logic [2:0] REG_ATK     = 3'd4;
  localparam logic [2:0] REG_SUS     = 3'd5;
  localparam logic [2:0] REG_WAV     = 3'd6;

  localparam logic [7:0] GATE  = 8'h01;
  localparam logic [7:0] TRI   = 8'h10;
  localparam logic [7:0] SAW   = 8'h20;
  localparam logic [7:0] PULSE = 8'h40;

  localparam int NUM_VOICES_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } sid_seq_state_e;

endpackage

// File: rtl/sid_rr_arb2.sv
// sid_rr_arb2
// Two-way round-robin grant. When both requesters are valid, the one that
// was not served last wins; a lone requester always wins.
// Ports:
//   a_valid_i     port A request
//   b_valid_i     port B request
//   last_grant_i  0 = A served last, 1 = B served last
//   grant_o       one-hot grant, bit 0 = A, bit 1 = B (all zero if no request)
module sid_rr_arb2 (
  input  logic       a_valid_i,
  input  logic       b_valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // Pure combinational pick; the caller owns the last_grant history register.
  always_comb begin
    grant_o = 2'b00;
    if (a_valid_i && b_valid_i) begin
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end else if (a_valid_i) begin
      grant_o = 2'b01;
    end else if (b_valid_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/sid_reg_arbiter.sv
// sid_reg_arbiter
// Arbitrates register writes from a host port (A) and a note-player port (B)
// and serialises each accepted write onto the SID bus as a
// SETUP / STROBE / HOLD sequence.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   ena                           advance enable, low freezes everything
//   a_valid/a_ready, a_addr/a_voice/a_data   port A request
//   b_valid/b_ready, b_addr/b_voice/b_data   port B request
//   sid_addr/sid_voice/sid_data   registered bus toward ui_in / uio_in
//   sid_we                        write strobe toward ui_in[7]
//   busy                          sequencer not idle
//   err_voice                     one-cycle pulse for a dropped bad-voice write
//   last_grant                    0 = A served last, 1 = B served last
//   wr_count                      strobes issued, wraps at 2^16
module sid_reg_arbiter
  import sid_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int NUM_VOICES  = NUM_VOICES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_addr,
  input  logic [1:0]  a_voice,
  input  logic [7:0]  a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [2:0]  b_addr,
  input  logic [1:0]  b_voice,
  input  logic [7:0]  b_data,
  output logic [2:0]  sid_addr,
  output logic [1:0]  sid_voice,
  output logic [7:0]  sid_data,
  output logic        sid_we,
  output logic        busy,
  output logic        err_voice,
  output logic        last_grant,
  output logic [15:0] wr_count
);

  localparam logic [3:0] HOLD_INIT   = 4'(HOLD_CYCLES);
  // A 2-bit voice can never reach 4, so any NUM_VOICES >= 4 accepts all.
  localparam logic [2:0] VOICE_LIMIT = (NUM_VOICES >= 4) ? 3'd4 : 3'(NUM_VOICES);

  sid_seq_state_e state_q;
  logic [3:0]     hold_cnt_q;
  logic [2:0]     sid_addr_q;
  logic [1:0]     sid_voice_q;
  logic [7:0]     sid_data_q;
  logic           sid_we_q;
  logic           busy_q;
  logic           err_voice_q;
  logic           last_grant_q;
  logic [15:0]    wr_count_q;
  logic [15:0]    wr_count_d;

  logic [1:0]     grant;
  logic           a_fire;
  logic           b_fire;
  logic [2:0]     req_addr;
  logic [1:0]     req_voice;
  logic [7:0]     req_data;
  logic           req_legal;

  sid_rr_arb2 u_arb (
    .a_valid_i    (a_valid),
    .b_valid_i    (b_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Ready only goes to the arbitration winner, and only while idle and
  // enabled, so at most one handshake can complete per edge.
  assign a_ready = ena && (state_q == ST_IDLE) && grant[0];
  assign b_ready = ena && (state_q == ST_IDLE) && grant[1];
  assign a_fire  = a_valid && a_ready;
  assign b_fire  = b_valid && b_ready;

  // Payload of whichever port completed its handshake this cycle.
  assign req_addr   = b_fire ? b_addr  : a_addr;
  assign req_voice  = b_fire ? b_voice : a_voice;
  assign req_data   = b_fire ? b_data  : a_data;
  assign req_legal  = {1'b0, req_voice} < VOICE_LIMIT;
  assign wr_count_d = wr_count_q + 16'd1;

  // Sequencer: every output is a register so the SID pins never glitch.
  // An illegal-voice request is still accepted (and counts for fairness)
  // but only raises err_voice; the bus and strobe are left untouched.
  // HOLD is timed by a down-counter loaded on leaving STROBE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= 4'd0;
      sid_addr_q   <= 3'd0;
      sid_voice_q  <= 2'd0;
      sid_data_q   <= 8'd0;
      sid_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_voice_q  <= 1'b0;
      last_grant_q <= 1'b1;
      wr_count_q   <= 16'd0;
    end else if (ena) begin
      err_voice_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (a_fire || b_fire) begin
            last_grant_q <= b_fire;
            if (req_legal) begin
              sid_addr_q  <= req_addr;
              sid_voice_q <= req_voice;
              sid_data_q  <= req_data;
              busy_q      <= 1'b1;
              state_q     <= ST_SETUP;
            end else begin
              err_voice_q <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          sid_we_q   <= 1'b1;
          wr_count_q <= wr_count_d;
          state_q    <= ST_STROBE;
        end
        ST_STROBE: begin
          sid_we_q   <= 1'b0;
          hold_cnt_q <= HOLD_INIT;
          state_q    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt_q <= 4'd1) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sid_addr   = sid_addr_q;
  assign sid_voice  = sid_voice_q;
  assign sid_data   = sid_data_q;
  assign sid_we     = sid_we_q;
  assign busy       = busy_q;
  assign err_voice  = err_voice_q;
  assign last_grant = last_grant_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_sid_reg_arbiter.sv
// tb_sid_reg_arbiter
// Directed checks of the SID register arbiter with default parameters
// (HOLD_CYCLES = 1, NUM_VOICES = 3). Inputs change 1 time unit after the
// rising edge and outputs are read 1 time unit later.
module tb_sid_reg_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_addr;
  logic [1:0]  a_voice;
  logic [7:0]  a_data;
  logic        b_valid;
  logic        b_ready;
  logic [2:0]  b_addr;
  logic [1:0]  b_voice;
  logic [7:0]  b_data;
  logic [2:0]  sid_addr;
  logic [1:0]  sid_voice;
  logic [7:0]  sid_data;
  logic        sid_we;
  logic        busy;
  logic        err_voice;
  logic        last_grant;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  sid_reg_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_voice    (a_voice),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_voice    (b_voice),
    .b_data     (b_data),
    .sid_addr   (sid_addr),
    .sid_voice  (sid_voice),
    .sid_data   (sid_data),
    .sid_we     (sid_we),
    .busy       (busy),
    .err_voice  (err_voice),
    .last_grant (last_grant),
    .wr_count   (wr_count)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  // Reset for two cycles and confirm every output's reset value.
  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1;
    a_valid = 1'b0; a_addr = 3'd0; a_voice = 2'd0; a_data = 8'd0;
    b_valid = 1'b0; b_addr = 3'd0; b_voice = 2'd0; b_data = 8'd0;
    tick(); tick();
    checks++; if ({sid_addr, sid_voice, sid_data} !== 13'd0) begin errors++;
      $display("[TB] FAIL reset_bus: got %h expected 0", {sid_addr, sid_voice, sid_data}); end
    checks++; if ({sid_we, busy, err_voice} !== 3'b000) begin errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {sid_we, busy, err_voice}); end
    checks++; if (last_grant !== 1'b1) begin errors++;
      $display("[TB] FAIL reset_last_grant: got %b expected 1", last_grant); end
    checks++; if (wr_count !== 16'd0) begin errors++;
      $display("[TB] FAIL reset_wr_count: got %0d expected 0", wr_count); end
    rst_n = 1'b1;
    tick();
  endtask

  // Both ports continuously valid: six grants alternating A, B, ... spaced
  // four cycles apart (last_grant starts at 1 after reset, so A goes first).
  task automatic test_back_to_back();
    int waited;
    logic exp_a;
    a_addr = 3'd1; a_voice = 2'd1; a_data = 8'h11;
    b_addr = 3'd5; b_voice = 2'd2; b_data = 8'h55;
    a_valid = 1'b1; b_valid = 1'b1;
    settle();
    for (int i = 0; i < 6; i++) begin
      waited = 0;
      while (!(a_ready || b_ready) && waited < 12) begin
        tick();
        waited++;
      end
      checks++; if (!(a_ready || b_ready)) begin errors++;
        $display("[TB] FAIL b2b_timeout: no ready within 12 cycles at grant %0d", i);
        break; end
      if (i > 0) begin
        checks++; if (waited + 1 !== 4) begin errors++;
          $display("[TB] FAIL b2b_spacing: grant %0d spacing %0d expected 4", i, waited + 1); end
      end
      exp_a = (i % 2 == 0);
      checks++; if ({a_ready, b_ready} !== {exp_a, ~exp_a}) begin errors++;
        $display("[TB] FAIL b2b_winner: grant %0d ready a/b %b%b expected %b%b",
                 i, a_ready, b_ready, exp_a, ~exp_a); end
      tick();
      if (i == 5) begin a_valid = 1'b0; b_valid = 1'b0; end
      checks++;
      if ({sid_addr, sid_voice, sid_data} !== (exp_a ? {3'd1, 2'd1, 8'h11} : {3'd5, 2'd2, 8'h55})) begin
        errors++;
        $display("[TB] FAIL b2b_bus: grant %0d got %h/%h/%h", i, sid_addr, sid_voice, sid_data); end
    end
    tick(); tick(); tick();
    checks++; if (wr_count !== 16'd6) begin errors++;
      $display("[TB] FAIL b2b_wr_count: got %0d expected 6", wr_count); end
    checks++; if ({busy, last_grant} !== 2'b01) begin errors++;
      $display("[TB] FAIL b2b_end_state: busy/last_grant %b expected 01", {busy, last_grant}); end
  endtask

  // Single write on A: bus timing, one-cycle strobe, return to idle at N+4.
  task automatic test_a_only();
    a_addr = 3'd0; a_voice = 2'd0; a_data = 8'h2C; a_valid = 1'b1;
    settle();
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++;
      $display("[TB] FAIL a_only_ready: got %b expected 10", {a_ready, b_ready}); end
    tick();
    a_valid = 1'b0;
    checks++; if ({sid_addr, sid_voice, sid_data} !== {3'd0, 2'd0, 8'h2C}) begin errors++;
      $display("[TB] FAIL a_only_bus: got %h/%h/%h expected 0/0/2c", sid_addr, sid_voice, sid_data); end
    checks++; if ({sid_we, busy} !== 2'b01) begin errors++;
      $display("[TB] FAIL a_only_setup: we/busy %b expected 01", {sid_we, busy}); end
    tick();
    checks++; if ({sid_we, wr_count} !== {1'b1, 16'd7}) begin errors++;
      $display("[TB] FAIL a_only_strobe: we %b count %0d expected 1 and 7", sid_we, wr_count); end
    tick();
    checks++; if ({sid_we, busy} !== 2'b01) begin errors++;
      $display("[TB] FAIL a_only_hold: we/busy %b expected 01", {sid_we, busy}); end
    tick();
    a_valid = 1'b1;
    settle();
    checks++; if ({busy, a_ready} !== 2'b01) begin errors++;
      $display("[TB] FAIL a_only_next_ready: busy/a_ready %b expected 01", {busy, a_ready}); end
    a_valid = 1'b0;
    settle();
  endtask

  // B request with voice 3 is accepted and dropped; A follows immediately
  // with unused address 7, which must pass straight through.
  task automatic test_illegal_voice();
    b_addr = 3'd6; b_voice = 2'd3; b_data = 8'h41; b_valid = 1'b1;
    settle();
    checks++; if (b_ready !== 1'b1) begin errors++;
      $display("[TB] FAIL bad_voice_ready: got %b expected 1", b_ready); end
    tick();
    b_valid = 1'b0;
    checks++; if ({err_voice, busy, sid_we} !== 3'b100) begin errors++;
      $display("[TB] FAIL bad_voice_flags: err/busy/we %b expected 100", {err_voice, busy, sid_we}); end
    checks++; if ({sid_addr, sid_voice, sid_data} !== {3'd0, 2'd0, 8'h2C}) begin errors++;
      $display("[TB] FAIL bad_voice_bus: got %h/%h/%h expected 0/0/2c", sid_addr, sid_voice, sid_data); end
    checks++; if ({last_grant, wr_count} !== {1'b1, 16'd7}) begin errors++;
      $display("[TB] FAIL bad_voice_state: last_grant %b count %0d expected 1 and 7", last_grant, wr_count); end
    a_addr = 3'd7; a_voice = 2'd2; a_data = 8'h99; a_valid = 1'b1;
    settle();
    checks++; if (a_ready !== 1'b1) begin errors++;
      $display("[TB] FAIL bad_voice_next_ready: got %b expected 1", a_ready); end
    tick();
    a_valid = 1'b0;
    checks++; if ({err_voice, sid_addr, sid_voice, sid_data} !== {1'b0, 3'd7, 2'd2, 8'h99}) begin errors++;
      $display("[TB] FAIL addr7_bus: err %b bus %h/%h/%h expected 0 7/2/99", err_voice, sid_addr, sid_voice, sid_data); end
    tick();
    checks++; if ({sid_we, wr_count} !== {1'b1, 16'd8}) begin errors++;
      $display("[TB] FAIL addr7_strobe: we %b count %0d expected 1 and 8", sid_we, wr_count); end
    tick(); tick();
  endtask

  // ena low for 5 cycles during STROBE stretches sid_we to 6 cycles;
  // ena low in IDLE blocks ready.
  task automatic test_ena_stall();
    int we_high;
    a_addr = 3'd2; a_voice = 2'd1; a_data = 8'h80; a_valid = 1'b1;
    settle();
    tick();
    a_valid = 1'b0;
    tick();
    we_high = 0;
    if (sid_we === 1'b1) we_high++;
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sid_we === 1'b1) we_high++;
    end
    checks++; if ({busy, wr_count} !== {1'b1, 16'd9}) begin errors++;
      $display("[TB] FAIL stall_frozen: busy %b count %0d expected 1 and 9", busy, wr_count); end
    ena = 1'b1;
    tick();
    checks++; if (we_high !== 6 || sid_we !== 1'b0) begin errors++;
      $display("[TB] FAIL stall_we_len: high %0d cycles, we now %b, expected 6 and 0", we_high, sid_we); end
    tick();
    checks++; if ({busy, wr_count} !== {1'b0, 16'd9}) begin errors++;
      $display("[TB] FAIL stall_complete: busy %b count %0d expected 0 and 9", busy, wr_count); end
    ena = 1'b0; a_valid = 1'b1;
    settle();
    checks++; if (a_ready !== 1'b0) begin errors++;
      $display("[TB] FAIL idle_ena_low_ready: got %b expected 0", a_ready); end
    tick();
    checks++; if ({busy, wr_count} !== {1'b0, 16'd9}) begin errors++;
      $display("[TB] FAIL idle_ena_low_hold: busy %b count %0d expected 0 and 9", busy, wr_count); end
    ena = 1'b1; a_valid = 1'b0;
    settle();
  endtask

  // Reset during SETUP discards the write; A then wins the first tie.
  task automatic test_reset_mid();
    int we_seen;
    a_addr = 3'd4; a_voice = 2'd0; a_data = 8'h0F; a_valid = 1'b1;
    settle();
    tick();
    a_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if ({sid_addr, sid_voice, sid_data, sid_we, busy, err_voice} !== 16'd0) begin errors++;
      $display("[TB] FAIL midreset_outputs: bus %h/%h/%h we/busy/err %b%b%b expected all 0",
               sid_addr, sid_voice, sid_data, sid_we, busy, err_voice); end
    checks++; if ({last_grant, wr_count} !== {1'b1, 16'd0}) begin errors++;
      $display("[TB] FAIL midreset_state: last_grant %b count %0d expected 1 and 0", last_grant, wr_count); end
    we_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (sid_we === 1'b1) we_seen++;
    end
    checks++; if (we_seen !== 0 || wr_count !== 16'd0) begin errors++;
      $display("[TB] FAIL midreset_no_strobe: strobes %0d count %0d expected 0 and 0", we_seen, wr_count); end
    a_valid = 1'b1; b_valid = 1'b1;
    settle();
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++;
      $display("[TB] FAIL midreset_tie: ready a/b %b expected 10", {a_ready, b_ready}); end
    a_valid = 1'b0; b_valid = 1'b0;
    settle();
  endtask

  initial begin
    $display("[TB] sid_reg_arbiter directed test start");
    test_reset();
    test_back_to_back();
    test_a_only();
    test_illegal_voice();
    test_ena_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
